// File: rtl/ctrl_imem_pkg.sv
// ============================================================================
// Module : ctrl_imem_pkg
// Brief  : Shared controller types and the instruction-width derivation.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ctrl_imem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam int C_VEC_ID_WIDTH        = 3;
    localparam int C_REGFILE_ADDR_WIDTH  = 3;
    localparam int C_DATA_ADDR_WIDTH     = 4;

    // Word layout: two flag bits, vector id, two register addresses, three data addresses.
    function automatic int instr_width(input int vec_id_w,
                                       input int rf_addr_w,
                                       input int data_addr_w);
        return 2 + vec_id_w + 2 * rf_addr_w + 3 * data_addr_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_imem_ram.sv
// ============================================================================
// Module : ctrl_imem_ram
// Brief  : Program storage, one write port and one registered read port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ctrl_imem_ram #(
    parameter int DATA_WIDTH = 23,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    // No reset: contents are only meaningful below the stored program length.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/ctrl_imem.sv
// ============================================================================
// Module : ctrl_imem
// Brief  : Loadable instruction memory with IDLE/LOAD/RUN control.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ctrl_imem
    import ctrl_imem_pkg::*;
#(
    parameter int INSTR_WIDTH      = instr_width(C_VEC_ID_WIDTH,
                                                 C_REGFILE_ADDR_WIDTH,
                                                 C_DATA_ADDR_WIDTH),
    parameter int INSTR_ADDR_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        prog,
    input  logic                        ld_valid,
    input  logic [INSTR_WIDTH-1:0]      ld_data,
    input  logic                        ld_last,
    output logic                        ld_ready,
    input  logic                        fetch,
    input  logic [INSTR_ADDR_WIDTH-1:0] pc,
    output logic [INSTR_WIDTH-1:0]      instr_word,
    output logic                        prog_done,
    output logic [INSTR_ADDR_WIDTH:0]   prog_len,
    output logic                        ld_err
);

    localparam int LEN_W = INSTR_ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** INSTR_ADDR_WIDTH;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   wptr_q, wptr_d;
    logic               prog_done_q, prog_done_d;
    logic               ld_err_q, ld_err_d;
    logic               zero_q, zero_d;
    logic               prog_prev_q;

    logic               ready_w;
    logic               accept_w;
    logic               prog_rise_w;
    logic               last_slot_w;
    logic               fetch_ok_w;
    logic               fetch_hit_w;
    logic [INSTR_WIDTH-1:0] rdata_w;

    assign ready_w     = (state_q == ST_LOAD) && prog;
    assign accept_w    = ready_w && ld_valid;
    // prog_prev resets high so a level held through reset never starts a load.
    assign prog_rise_w = prog && !prog_prev_q;
    assign last_slot_w = (wptr_q == LEN_W'(DEPTH - 1));
    assign fetch_ok_w  = (state_q == ST_RUN) && fetch && !prog;
    assign fetch_hit_w = fetch_ok_w && ({1'b0, pc} < wptr_q);

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        prog_done_d = prog_done_q;
        ld_err_d    = ld_err_q;
        zero_d      = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (prog_rise_w) begin
                    state_d     = ST_LOAD;
                    wptr_d      = '0;
                    prog_done_d = 1'b0;
                    ld_err_d    = 1'b0;
                end
            end
            ST_LOAD: begin
                if (!prog) begin
                    state_d     = ST_IDLE;
                    wptr_d      = '0;
                    prog_done_d = 1'b0;
                end else if (accept_w) begin
                    wptr_d = wptr_q + LEN_W'(1);
                    if (ld_last || last_slot_w) begin
                        state_d     = ST_RUN;
                        prog_done_d = 1'b1;
                        ld_err_d    = !ld_last;
                    end
                end
            end
            ST_RUN: begin
                if (prog_rise_w) begin
                    state_d     = ST_LOAD;
                    wptr_d      = '0;
                    prog_done_d = 1'b0;
                    ld_err_d    = 1'b0;
                end else if (fetch_ok_w) begin
                    zero_d = !fetch_hit_w;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wptr_q      <= '0;
            prog_done_q <= 1'b0;
            ld_err_q    <= 1'b0;
            zero_q      <= 1'b1;
            prog_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            prog_done_q <= prog_done_d;
            ld_err_q    <= ld_err_d;
            zero_q      <= zero_d;
            prog_prev_q <= prog;
        end
    end

    ctrl_imem_ram #(
        .DATA_WIDTH (INSTR_WIDTH),
        .ADDR_WIDTH (INSTR_ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (accept_w),
        .waddr_i (wptr_q[INSTR_ADDR_WIDTH-1:0]),
        .wdata_i (ld_data),
        .re_i    (fetch_hit_w),
        .raddr_i (pc),
        .rdata_o (rdata_w)
    );

    // Out-of-range fetches and reset mask the unreset RAM output to zero.
    assign instr_word = zero_q ? '0 : rdata_w;
    assign ld_ready   = ready_w;
    assign prog_done  = prog_done_q;
    assign prog_len   = wptr_q;
    assign ld_err     = ld_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_imem.sv
// ============================================================================
// Module : tb_ctrl_imem
// Brief  : Randomized self-checking bench for ctrl_imem against a program model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ctrl_imem;

    localparam int IW    = 23;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          prog;
    logic          ld_valid;
    logic [IW-1:0] ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic          fetch;
    logic [AW-1:0] pc;
    logic [IW-1:0] instr_word;
    logic          prog_done;
    logic [AW:0]   prog_len;
    logic          ld_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: stored words, length, completion/error flags, last fetched word.
    logic [IW-1:0] m_mem [DEPTH];
    int            m_len;
    bit            m_done;
    bit            m_err;
    bit            m_loading;
    logic [IW-1:0] m_instr;

    always #5 clk = ~clk;

    ctrl_imem #(
        .INSTR_WIDTH      (IW),
        .INSTR_ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .prog       (prog),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .fetch      (fetch),
        .pc         (pc),
        .instr_word (instr_word),
        .prog_done  (prog_done),
        .prog_len   (prog_len),
        .ld_err     (ld_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag);
        check({tag, ".done"}, 32'(prog_done), 32'(m_done));
        check({tag, ".len"},  32'(prog_len),  32'(m_len));
        check({tag, ".err"},  32'(ld_err),    32'(m_err));
    endtask

    task automatic begin_load();
        prog = 1'b0;
        tick();
        prog = 1'b1;
        tick();
        m_len     = 0;
        m_done    = 1'b0;
        m_err     = 1'b0;
        m_loading = 1'b1;
        check("load_entry.ready", 32'(ld_ready), 32'd1);
        check_status("load_entry");
    endtask

    // Loads up to n words (ld_last on the n-th when use_last); fixed words used first.
    task automatic load_program(input int n, input bit use_last, input int valid_pct,
                                input logic [IW-1:0] fixed[$]);
        int cycles = 0;
        logic [IW-1:0] w;
        begin_load();
        while (m_loading && cycles < 2000) begin
            w        = (m_len < fixed.size()) ? fixed[m_len] : IW'($urandom);
            ld_valid = ($urandom_range(0, 99) < valid_pct);
            ld_data  = w;
            ld_last  = use_last && (m_len == n - 1);
            check("load.ready", 32'(ld_ready), 32'd1);
            tick();
            if (ld_valid) begin
                m_mem[m_len] = w;
                m_len++;
                if (ld_last || m_len == DEPTH) begin
                    m_done    = 1'b1;
                    m_err     = !ld_last;
                    m_loading = 1'b0;
                end
            end
            check("load.len", 32'(prog_len), 32'(m_len));
            cycles++;
        end
        if (m_loading) check("load.timeout", 32'd0, 32'd1);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check_status("load_end");
        check("load_end.ready", 32'(ld_ready), 32'd0);
    endtask

    task automatic fetch_at(input int p);
        prog  = 1'b0;
        fetch = 1'b1;
        pc    = AW'(p);
        tick();
        fetch = 1'b0;
        if (m_done) m_instr = (p < m_len) ? m_mem[p] : '0;
        check($sformatf("fetch.pc%0d", p), 32'(instr_word), 32'(m_instr));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IW-1:0] none[$];
        logic [IW-1:0] req35[$];
        rst = 1'b1; prog = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        fetch = 1'b0; pc = '0;
        m_len = 0; m_done = 1'b0; m_err = 1'b0; m_loading = 1'b0; m_instr = '0;
        tick();
        tick();
        check("rst.ready", 32'(ld_ready),   32'd0);
        check("rst.instr", 32'(instr_word), 32'd0);
        check_status("rst");
        rst = 1'b0;
        tick();

        fetch_at(0);

        // Three words, last on the third.
        req35 = '{IW'(24'h000011), IW'(24'h000022), IW'(24'h000033)};
        load_program(3, 1'b1, 100, req35);
        check("p3.len", 32'(prog_len), 32'd3);
        // Holding prog high after completion must not reopen loading or fetch.
        ld_valid = 1'b1; ld_data = IW'(24'h0000AA); fetch = 1'b1; pc = 4'd0;
        for (int i = 0; i < 2; i++) begin
            check("run_hold.ready", 32'(ld_ready), 32'd0);
            tick();
            check("run_hold.len",   32'(prog_len),   32'd3);
            check("run_hold.instr", 32'(instr_word), 32'(m_instr));
        end
        ld_valid = 1'b0; fetch = 1'b0;
        fetch_at(1);
        check("p3.word1", 32'(instr_word), 32'h000022);

        // Overflow: sixteen words without ld_last.
        load_program(DEPTH, 1'b0, 100, none);
        check("ovf.err", 32'(ld_err), 32'd1);
        check("ovf.len", 32'(prog_len), 32'd16);
        fetch_at(15);

        // Abort after two words.
        begin_load();
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1; ld_data = IW'($urandom);
            tick();
        end
        ld_valid = 1'b0;
        prog = 1'b0;
        tick();
        m_len = 0; m_done = 1'b0; m_loading = 1'b0;
        check_status("abort");
        tick();
        check("abort.ready", 32'(ld_ready), 32'd0);
        fetch_at(0);

        // Length four: out-of-range and last-word fetches.
        load_program(4, 1'b1, 100, none);
        fetch_at(7);
        fetch_at(3);
        fetch_at(4);

        // Stalling valid; every address read back.
        load_program(6, 1'b1, 50, none);
        for (int p = 0; p < DEPTH; p++) fetch_at(p);

        // Random programs.
        for (int it = 0; it < 6; it++) begin
            load_program($urandom_range(1, DEPTH), ($urandom_range(0, 3) != 0),
                         $urandom_range(30, 100), none);
            for (int k = 0; k < 8; k++) fetch_at($urandom_range(0, DEPTH - 1));
        end

        // Reset between edges in the middle of a load.
        begin_load();
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1; ld_data = IW'($urandom);
            tick();
        end
        ld_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        m_len = 0; m_done = 1'b0; m_err = 1'b0; m_loading = 1'b0; m_instr = '0;
        check("midrst.ready", 32'(ld_ready),   32'd0);
        check("midrst.instr", 32'(instr_word), 32'd0);
        check_status("midrst");
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("midrst.no_rise", 32'(ld_ready), 32'd0);
        load_program(2, 1'b1, 100, none);
        fetch_at(0);
        fetch_at(1);
        fetch_at(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
